// File: rtl/gray_counter_ud.sv
// gray_counter_ud: parametrised up/down Gray-code counter.
// The count is held in binary; the Gray output is a registered conversion of
// the next binary value, so out and bin_out always describe the same count
// and neither output can glitch.
// Optional feature: define GRAY_CNT_SAT_EN to make the counter saturate at
// 0 and all-ones instead of wrapping.
module gray_counter_ud #(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] out,
    output logic [DATA_WIDTH-1:0] bin_out,
    output logic                  tc
);

    localparam logic [DATA_WIDTH-1:0] RST_BIN  = DATA_WIDTH'(RESET_VALUE);
    localparam logic [DATA_WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] bin_q, bin_d;
    logic [DATA_WIDTH-1:0] gray_q, gray_d;
    logic                  tc_q, tc_d;
    logic                  at_max, at_min;

    assign at_max = &bin_q;
    assign at_min = ~|bin_q;

    // Next count and terminal-event detection: load beats count beats hold.
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                tc_d = at_max;
`ifdef GRAY_CNT_SAT_EN
                if (!at_max) bin_d = bin_q + ONE;
`else
                bin_d = bin_q + ONE;
`endif
            end else begin
                tc_d = at_min;
`ifdef GRAY_CNT_SAT_EN
                if (!at_min) bin_d = bin_q - ONE;
`else
                bin_d = bin_q - ONE;
`endif
            end
        end
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State and output registers; reset takes effect immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    assign bin_out = bin_q;
    assign out     = gray_q;
    assign tc      = tc_q;

endmodule
